// File: rtl/adc_burst_sequencer.sv
// Sequences one asynchronous fill into the DDR3 write FIFO: a fill header, then per trigger
// a waveform header plus sample bursts, and finally an XOR checksum trailer.
module adc_burst_sequencer #(
    parameter int SAMPLE_W   = 12,
    parameter int NSAMP      = 8,
    parameter bit ASYNC_MODE = 1'b1,
    parameter int WFM_CNT_W  = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fill_start,
    input  logic                          fill_end,
    input  logic [23:0]                   fill_num,
    input  logic [1:0]                    fill_type,
    input  logic [11:0]                   channel_tag,
    input  logic [10:0]                   async_num_bursts,
    input  logic [11:0]                   async_pre_trig,
    input  logic [3:0]                    xadc_alarms,
    input  logic                          wfm_trig,
    input  logic [22:0]                   wfm_start_adr,
    input  logic [NSAMP*(SAMPLE_W+1)-1:0] s_dat,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [131:0]                  out_dat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [WFM_CNT_W-1:0]          wfm_count,
    output logic [22:0]                   burst_count,
    output logic [15:0]                   missed_trig
);

    // Handshakes: a word moves when valid and ready are both high in the same cycle;
    // out_dat is held while out_valid=1 and out_ready=0.
    localparam int SLICE_W = SAMPLE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_HDR,
        S_WAIT_TRIG,
        S_WFM_HDR,
        S_DATA,
        S_CHECKSUM
    } state_t;

    state_t state, state_nxt;

    logic [23:0]  fill_num_r;
    logic [1:0]   fill_type_r;
    logic [11:0]  channel_tag_r;
    logic [10:0]  num_bursts_r;
    logic [11:0]  pre_trig_r;
    logic [22:0]  wfm_adr_r;
    logic         end_latched;
    logic         loaded;
    logic [10:0]  burst_left;
    logic [127:0] csum;

    logic         xfer;
    logic         can_load;
    logic         load;
    logic [131:0] load_dat;
    logic         fill_acc;
    logic         trig_acc;
    logic         wfm_done;
    logic         miss;

    logic [127:0]        fill_hdr;
    logic [127:0]        wfm_hdr;
    logic [127:0]        data_word;
    logic [22:0]         wfm_idx;
    logic [SAMPLE_W-1:0] samp;
    logic [NSAMP-1:0]    ovr_bits;
    logic                unused_ovr;

    assign xfer     = out_valid & out_ready;
    assign can_load = ~out_valid | out_ready;
    assign fill_acc = (state == S_IDLE) & fill_start;
    assign trig_acc = (state == S_WAIT_TRIG) & wfm_trig;
    assign miss     = wfm_trig & (state != S_WAIT_TRIG);
    assign wfm_done = (state == S_WFM_HDR) & loaded & xfer;
    assign busy     = (state != S_IDLE);
    assign wfm_idx  = 23'(wfm_count);

    always_comb begin
        fill_hdr = {2'b01, 4'b0, channel_tag_r, 83'b0, ASYNC_MODE, fill_type_r, fill_num_r};
        wfm_hdr  = {2'b01, 12'b0, xadc_alarms, channel_tag_r, 23'b0, wfm_idx,
                    wfm_adr_r, 3'b000, ASYNC_MODE, fill_type_r, pre_trig_r, num_bursts_r};
        data_word = '0;
        ovr_bits  = '0;
        samp      = '0;
        for (int i = 0; i < NSAMP; i++) begin
            samp        = s_dat[i*SLICE_W+1 +: SAMPLE_W];
            ovr_bits[i] = s_dat[i*SLICE_W];
            data_word[16*i +: 16] = {{(16-SAMPLE_W){samp[SAMPLE_W-1]}}, samp};
        end
    end

    // Over-range flags are carried on the stream but not stored.
    assign unused_ovr = ^ovr_bits;

    // Header/trailer states load exactly one word (tracked by loaded) and leave on its transfer.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_dat  = '0;
        s_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill_start) state_nxt = S_FILL_HDR;
            end
            S_FILL_HDR: begin
                if (!loaded && can_load) begin
                    load     = 1'b1;
                    load_dat = {4'd1, fill_hdr};
                end else if (loaded && xfer) begin
                    state_nxt = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (wfm_trig) state_nxt = S_WFM_HDR;
                else if (fill_end || end_latched) state_nxt = S_CHECKSUM;
            end
            S_WFM_HDR: begin
                if (!loaded && can_load) begin
                    load     = 1'b1;
                    load_dat = {4'd2, wfm_hdr};
                end else if (loaded && xfer) begin
                    state_nxt = (num_bursts_r == 11'd0) ? S_WAIT_TRIG : S_DATA;
                end
            end
            S_DATA: begin
                s_ready = can_load;
                if (s_valid && can_load) begin
                    load     = 1'b1;
                    load_dat = {4'd3, data_word};
                    if (burst_left == 11'd1)
                        state_nxt = end_latched ? S_CHECKSUM : S_WAIT_TRIG;
                end
            end
            S_CHECKSUM: begin
                // The last data word may transfer in the very cycle the trailer loads.
                if (!loaded && can_load) begin
                    load     = 1'b1;
                    load_dat = {4'd4, csum ^ (xfer ? out_dat[127:0] : 128'd0)};
                end else if (loaded && xfer) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            loaded <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) loaded <= 1'b0;
            else if (load)          loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_dat   <= load_dat;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_num_r    <= '0;
            fill_type_r   <= '0;
            channel_tag_r <= '0;
            num_bursts_r  <= '0;
            pre_trig_r    <= '0;
            wfm_adr_r     <= '0;
            end_latched   <= 1'b0;
            burst_left    <= '0;
            csum          <= '0;
            wfm_count     <= '0;
            burst_count   <= '0;
            missed_trig   <= '0;
        end else begin
            if (fill_acc) begin
                fill_num_r    <= fill_num;
                fill_type_r   <= fill_type;
                channel_tag_r <= channel_tag;
                num_bursts_r  <= async_num_bursts;
                pre_trig_r    <= async_pre_trig;
                end_latched   <= 1'b0;
                csum          <= '0;
                wfm_count     <= '0;
                burst_count   <= '0;
                missed_trig   <= '0;
            end else begin
                if (xfer) burst_count <= burst_count + 23'd1;
                if (xfer && !(state == S_CHECKSUM && loaded)) csum <= csum ^ out_dat[127:0];
                if (wfm_done) wfm_count <= wfm_count + WFM_CNT_W'(1);
                if (miss && missed_trig != 16'hFFFF) missed_trig <= missed_trig + 16'd1;
                if (fill_end && state inside {S_FILL_HDR, S_WAIT_TRIG, S_WFM_HDR, S_DATA})
                    end_latched <= 1'b1;
            end
            if (trig_acc) wfm_adr_r <= wfm_start_adr;
            if (wfm_done)                     burst_left <= num_bursts_r;
            else if (state == S_DATA && load) burst_left <= burst_left - 11'd1;
        end
    end

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Directed bench for adc_burst_sequencer: expected FIFO words are queued as stimulus is driven
// and compared in order as the DUT hands them over.
module tb_adc_burst_sequencer;

    localparam logic [11:0] PRE = 12'h055;
    localparam logic [3:0]  ALM = 4'h5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fill_start = 1'b0;
    logic         fill_end = 1'b0;
    logic [23:0]  fill_num = '0;
    logic [1:0]   fill_type = '0;
    logic [11:0]  channel_tag = '0;
    logic [10:0]  async_num_bursts = '0;
    logic [11:0]  async_pre_trig = PRE;
    logic [3:0]   xadc_alarms = ALM;
    logic         wfm_trig = 1'b0;
    logic [22:0]  wfm_start_adr = '0;
    logic [103:0] s_dat = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [131:0] out_dat;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic [22:0]  wfm_count;
    logic [22:0]  burst_count;
    logic [15:0]  missed_trig;

    logic [131:0] exp_q[$];
    logic [127:0] csum_m = '0;
    logic [103:0] sx_raw;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adc_burst_sequencer dut (
        .clk(clk), .rst(rst), .fill_start(fill_start), .fill_end(fill_end),
        .fill_num(fill_num), .fill_type(fill_type), .channel_tag(channel_tag),
        .async_num_bursts(async_num_bursts), .async_pre_trig(async_pre_trig),
        .xadc_alarms(xadc_alarms), .wfm_trig(wfm_trig), .wfm_start_adr(wfm_start_adr),
        .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .wfm_count(wfm_count), .burst_count(burst_count),
        .missed_trig(missed_trig)
    );

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [131:0] fhdr(input logic [23:0] n, input logic [1:0] t,
                                          input logic [11:0] c);
        logic [127:0] p;
        p = '0;
        p[23:0]    = n;
        p[25:24]   = t;
        p[26]      = 1'b1;
        p[121:110] = c;
        p[127:126] = 2'b01;
        return {4'd1, p};
    endfunction

    function automatic logic [131:0] whdr(input logic [22:0] adr, input logic [22:0] idx);
        logic [127:0] p;
        p = '0;
        p[10:0]    = async_num_bursts;
        p[22:11]   = PRE;
        p[24:23]   = fill_type;
        p[25]      = 1'b1;
        p[51:26]   = {adr, 3'b000};
        p[74:52]   = idx;
        p[109:98]  = channel_tag;
        p[113:110] = ALM;
        p[127:126] = 2'b01;
        return {4'd2, p};
    endfunction

    function automatic logic [103:0] ramp(input int b);
        logic [103:0] v;
        logic [11:0]  d;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            d = 12'(b * 300 + i * 517);
            v[13*i +: 13] = {d, 1'(i & 1)};
        end
        return v;
    endfunction

    function automatic logic [131:0] dword(input logic [103:0] v);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            p[16*i +: 16] = {{4{v[13*i+12]}}, v[13*i+1 +: 12]};
        return {4'd3, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [131:0] w);
        exp_q.push_back(w);
        csum_m = csum_m ^ w[127:0];
    endtask

    task automatic push_trailer();
        exp_q.push_back({4'd4, csum_m});
    endtask

    task automatic start_fill(input logic [23:0] n, input logic [1:0] t,
                              input logic [11:0] c, input logic [10:0] nb);
        tick();
        fill_num = n;
        fill_type = t;
        channel_tag = c;
        async_num_bursts = nb;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        csum_m = '0;
        push_word(fhdr(n, t, c));
    endtask

    task automatic trig(input logic [22:0] adr);
        tick();
        wfm_start_adr = adr;
        wfm_trig = 1'b1;
        tick();
        wfm_trig = 1'b0;
    endtask

    task automatic pulse_end();
        tick();
        fill_end = 1'b1;
        tick();
        fill_end = 1'b0;
    endtask

    task automatic accept_wait(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
        end
        check({tag, "_accept"}, got, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_burst(input logic [103:0] d, input string tag);
        tick();
        s_dat = d;
        s_valid = 1'b1;
        accept_wait(tag);
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Output scoreboard: every FIFO transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL extra_word: observed %h expected none", out_dat);
            end else begin
                check("out_word", out_dat, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_wfm_count", wfm_count, 0);
        check("rst_burst_count", burst_count, 0);
        check("rst_missed", missed_trig, 0);

        // fill_end ignored and wfm_trig counted while idle
        pulse_end();
        trig(23'h1);
        check("idle_busy", busy, 0);
        check("idle_missed", missed_trig, 1);
        check("idle_out_valid", out_valid, 0);

        // Basic fill: two ramp bursts on one waveform
        start_fill(24'h000123, 2'b10, 12'hABC, 11'd2);
        check("basic_missed_clr", missed_trig, 0);
        check("basic_busy", busy, 1);
        wait_drain("basic_fhdr");
        trig(23'h10);
        push_word(whdr(23'h10, 23'd0));
        push_word(dword(ramp(0)));
        send_burst(ramp(0), "basic_b0");
        push_word(dword(ramp(1)));
        send_burst(ramp(1), "basic_b1");
        wait_drain("basic_data");
        pulse_end();
        push_trailer();
        wait_drain("basic_trl");
        tick();
        check("basic_busy_end", busy, 0);
        check("basic_burst_count", burst_count, 5);
        check("basic_wfm_count", wfm_count, 1);

        // Sign extension with hand-computed data word, maximum start address
        start_fill(24'h000124, 2'b01, 12'h123, 11'd1);
        wait_drain("sx_fhdr");
        trig(23'h7FFFFF);
        push_word(whdr(23'h7FFFFF, 23'd0));
        sx_raw = {13'h1002, 13'h0002, 13'h0001, 13'h1000, 13'h0FFF, 13'h1FFE, 13'h0FFE, 13'h1FFF};
        push_word({4'd3, 128'hF801_0001_0000_F800_07FF_FFFF_07FF_FFFF});
        send_burst(sx_raw, "sx_b0");
        wait_drain("sx_data");
        pulse_end();
        push_trailer();
        wait_drain("sx_trl");
        tick();
        check("sx_burst_count", burst_count, 4);

        // Backpressure mid-data
        start_fill(24'h000200, 2'b00, 12'h0F0, 11'd3);
        wait_drain("bp_fhdr");
        trig(23'h20);
        push_word(whdr(23'h20, 23'd0));
        wait_drain("bp_whdr");
        tick();
        out_ready = 1'b0;
        push_word(dword(ramp(2)));
        send_burst(ramp(2), "bp_a");
        push_word(dword(ramp(3)));
        s_dat = ramp(3);
        s_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_out_dat", out_dat, dword(ramp(2)));
            check("bp_burst_count", burst_count, 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        accept_wait("bp_b");
        push_word(dword(ramp(4)));
        send_burst(ramp(4), "bp_c");
        wait_drain("bp_data");
        pulse_end();
        push_trailer();
        wait_drain("bp_trl");
        tick();
        check("bp_burst_count_end", burst_count, 6);

        // Missed triggers during DATA, then fill_end coincident with wfm_trig
        start_fill(24'h000300, 2'b11, 12'h555, 11'd2);
        wait_drain("mt_fhdr");
        trig(23'h30);
        push_word(whdr(23'h30, 23'd0));
        push_word(dword(ramp(5)));
        send_burst(ramp(5), "mt_b0");
        repeat (3) trig(23'h1234);
        check("mt_missed", missed_trig, 3);
        push_word(dword(ramp(6)));
        send_burst(ramp(6), "mt_b1");
        wait_drain("mt_w0");
        tick();
        wfm_start_adr = 23'h40;
        wfm_trig = 1'b1;
        fill_end = 1'b1;
        tick();
        wfm_trig = 1'b0;
        fill_end = 1'b0;
        push_word(whdr(23'h40, 23'd1));
        push_word(dword(ramp(7)));
        send_burst(ramp(7), "mt_b2");
        push_word(dword(ramp(8)));
        send_burst(ramp(8), "mt_b3");
        push_trailer();
        wait_drain("mt_trl");
        tick();
        check("mt_busy_end", busy, 0);
        check("mt_wfm_count", wfm_count, 2);
        check("mt_missed_end", missed_trig, 3);
        check("mt_burst_count", burst_count, 8);

        // Zero bursts per waveform: headers only, stream never accepted
        start_fill(24'h000400, 2'b01, 12'h777, 11'd0);
        s_dat = ramp(9);
        s_valid = 1'b1;
        wait_drain("nb0_fhdr");
        trig(23'h50);
        push_word(whdr(23'h50, 23'd0));
        repeat (4) begin
            @(negedge clk);
            check("nb0_s_ready", s_ready, 0);
        end
        wait_drain("nb0_w0");
        trig(23'h60);
        push_word(whdr(23'h60, 23'd1));
        wait_drain("nb0_w1");
        s_valid = 1'b0;
        pulse_end();
        push_trailer();
        wait_drain("nb0_trl");
        tick();
        check("nb0_wfm_count", wfm_count, 2);
        check("nb0_burst_count", burst_count, 4);

        // Reset mid-DATA with a stalled word, then a clean fill
        start_fill(24'h000500, 2'b10, 12'h321, 11'd4);
        wait_drain("rs_fhdr");
        trig(23'h70);
        push_word(whdr(23'h70, 23'd0));
        wait_drain("rs_whdr");
        tick();
        out_ready = 1'b0;
        send_burst(ramp(10), "rs_b0");
        check("rs_pending", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rs_out_valid", out_valid, 0);
        check("rs_out_dat", out_dat, 0);
        check("rs_busy", busy, 0);
        check("rs_burst_count", burst_count, 0);
        check("rs_wfm_count", wfm_count, 0);
        check("rs_missed", missed_trig, 0);
        start_fill(24'h000600, 2'b10, 12'h321, 11'd1);
        wait_drain("rs2_fhdr");
        trig(23'h80);
        push_word(whdr(23'h80, 23'd0));
        push_word(dword(ramp(11)));
        send_burst(ramp(11), "rs2_b0");
        wait_drain("rs2_data");
        pulse_end();
        push_trailer();
        wait_drain("rs2_trl");
        tick();
        check("rs2_busy", busy, 0);
        check("rs2_burst_count", burst_count, 4);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
